scan_mux_n: RTL and testbench
=============================

# scan_mux_n

Parametrised, time-multiplexed N-channel selector for the digital clock display path. It scans through CHANNELS input words of WIDTH bits each and dwells DWELL clock cycles on each enabled channel, skipping masked-off channels. It drives a registered data word, binary and one-hot channel indices, and a frame-complete pulse to the segment/anode drivers. It replaces fixed-size combinational selection plus an external scan counter.

## Interface
- WIDTH, 6, bits per channel word (≥1)
- CHANNELS, 8, number of input channels (≥2, power of two not required)
- DWELL, 1000, clock cycles spent on each channel (≥2)
- SEL_W, $clog2(CHANNELS), derived; not overridden

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  scan enable; 0 freezes dwell counter and channel index
- ch_mask  in  CHANNELS  bit i = 1 enables channel i
- data_in  in  CHANNELS*WIDTH  flattened channel words; channel i at [i*WIDTH +: WIDTH]
- sel  out  SEL_W  current channel index (register)
- f  out  WIDTH  registered selected word
- sel_onehot  out  CHANNELS  registered one-hot of active channel; 0 when invalid
- valid  out  1  registered; f/sel_onehot carry an enabled channel
- frame_done  out  1  one-cycle pulse when the scan wraps

## Operation
- State: sel_r (SEL_W), cnt (dwell counter, $clog2(DWELL) bits), output registers.
- next_idx: the first index j > sel_r with ch_mask[j]=1, searching upward with wrap modulo CHANNELS. If sel_r is the only enabled channel, next_idx = sel_r.
- Per rising edge, priority order:
  - en=0: cnt and sel_r hold.
  - ch_mask = 0: cnt <= 0, sel_r holds.
  - ch_mask[sel_r]=0 (channel disabled mid-dwell): sel_r <= next_idx, cnt <= 0 on this edge. No wait for dwell end.
  - cnt = DWELL-1: cnt <= 0, sel_r <= next_idx.
  - otherwise: cnt <= cnt+1.
- frame_done <= 1 on an edge where sel_r advances and next_idx ≤ sel_r (wrap, including single-channel self-advance). Otherwise 0.
- Output registers sample the current (pre-update) sel_r every edge, regardless of en:
  - valid <= ch_mask[sel_r]
  - f <= valid-term ? data_in slice[sel_r] : 0
  - sel_onehot <= valid-term ? (1 << sel_r) : 0
- Out-of-range indices never occur because next_idx only returns enabled indices < CHANNELS.

## Timing
- Reset (async, immediate, no clock needed): sel=0, cnt=0, f=0, sel_onehot=0, valid=0, frame_done=0.
- First edge after reset release: outputs reflect channel 0 if ch_mask[0]=1.
- f, valid, and sel_onehot lag sel by exactly 1 cycle. data_in is sampled at that edge.
- Each enabled channel holds sel for exactly DWELL cycles while en=1 continuously.
- The en=0 gap does not count toward dwell. The remaining cycles complete on resume.
- frame_done is coincident with the sel update cycle (visible in the same cycle as the new sel), not lagged.
- Simultaneous mask change and dwell end: the disabled-current rule and the dwell-end rule give the same next_idx computed from the new mask.

## Configuration
- SCAN_MUX_BLANK_EN defined: for the first cycle of every dwell (cnt = 0 on the pre-update state), the output registers load valid=0, f=0, and sel_onehot=0. This provides anti-ghosting blanking. sel, cnt, and frame_done are unaffected.
- Undefined: no blanking; outputs follow the rules above.

## Test plan
Bench parameters: CHANNELS=4, WIDTH=6, DWELL=3; data ch0..3 = 10, 11, 12, 13; macro undefined unless stated.

- Reset, then release with ch_mask=4'b1111, en=1 → sel = 0,0,0,1,1,1,2,2,2,3,3,3,0. f = 10,10,10,11,… lagging sel by one cycle. frame_done is high exactly on the 3→0 cycle.
- ch_mask=4'b0101 → sel alternates 0 and 2 every 3 cycles. sel_onehot = 0001/0100. frame_done fires on each 2→0 transition.
- ch_mask=0 → one cycle later valid=0, f=0, sel_onehot=0. sel holds. frame_done stays 0.
- en=0 for 5 cycles at cnt=1 on channel 1 → sel stays 1. After en returns to 1, sel holds for 2 more cycles, then becomes 2.
- On channel 1 at cnt=0, clear ch_mask[1] → sel=2 on the next edge, with cnt restarted. Separately, assert reset asynchronously mid-scan → all outputs 0 before the next clk edge.
- SCAN_MUX_BLANK_EN with ch_mask=4'b1111 → valid=0 and f=0 on the first output cycle of each channel, then f=11 for the remaining 2 cycles of channel 1.

Source files
------------

// File: rtl/scan_mux_n.sv
// Time-multiplexed N-channel scanner for the clock display path: dwells DWELL cycles per enabled channel.
// Optional anti-ghosting blanking of the first output cycle of each dwell when SCAN_MUX_BLANK_EN is defined.
module scan_mux_n #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 8,
    parameter int DWELL    = 1000,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       ch_mask,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          f,
    output logic [CHANNELS-1:0]       sel_onehot,
    output logic                      valid,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(DWELL);

    logic [SEL_W-1:0]    sel_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [WIDTH-1:0]    f_r;
    logic [CHANNELS-1:0] onehot_r;
    logic                valid_r;
    logic                frame_done_r;

    logic [SEL_W-1:0]    next_idx_s;
    logic                wrap_s;
    logic                cur_on_s;
    logic                dwell_end_s;
    logic                any_on_s;
    logic                blank_s;
    logic                load_s;

    // Next enabled channel above sel_r with wrap; smallest upward distance wins, falls back to sel_r.
    always_comb begin
        int sum;
        int cand;
        sum        = 0;
        cand       = 0;
        next_idx_s = sel_r;
        for (int k = CHANNELS - 1; k >= 1; k--) begin
            sum        = int'(sel_r) + k;
            cand       = (sum >= CHANNELS) ? (sum - CHANNELS) : sum;
            next_idx_s = ch_mask[cand] ? SEL_W'(cand) : next_idx_s;
        end
    end

    // Scan control terms and the output-load qualifier for the current (pre-update) channel.
    always_comb begin
        cur_on_s    = ch_mask[sel_r];
        any_on_s    = |ch_mask;
        dwell_end_s = (cnt_r == CNT_W'(DWELL - 1));
        wrap_s      = (next_idx_s <= sel_r);
`ifdef SCAN_MUX_BLANK_EN
        blank_s     = (cnt_r == {CNT_W{1'b0}});
`else
        blank_s     = 1'b0;
`endif
        load_s      = cur_on_s && !blank_s;
    end

    // Dwell counter, channel index and frame pulse; a disabled current channel is left immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r        <= {SEL_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
        end else if (!en) begin
            frame_done_r <= 1'b0;
        end else if (!any_on_s) begin
            cnt_r        <= {CNT_W{1'b0}};
            frame_done_r <= 1'b0;
        end else if (!cur_on_s || dwell_end_s) begin
            sel_r        <= next_idx_s;
            cnt_r        <= {CNT_W{1'b0}};
            frame_done_r <= wrap_s;
        end else begin
            cnt_r        <= cnt_r + CNT_W'(1);
            frame_done_r <= 1'b0;
        end
    end

    // Output registers follow the pre-update channel every edge, independent of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_r      <= {WIDTH{1'b0}};
            onehot_r <= {CHANNELS{1'b0}};
            valid_r  <= 1'b0;
        end else if (load_s) begin
            f_r      <= data_in[int'(sel_r)*WIDTH +: WIDTH];
            onehot_r <= CHANNELS'(1) << sel_r;
            valid_r  <= 1'b1;
        end else begin
            f_r      <= {WIDTH{1'b0}};
            onehot_r <= {CHANNELS{1'b0}};
            valid_r  <= 1'b0;
        end
    end

    assign sel        = sel_r;
    assign f          = f_r;
    assign sel_onehot = onehot_r;
    assign valid      = valid_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_scan_mux_n.sv
// Table-driven bench for scan_mux_n with CHANNELS=4, WIDTH=6, DWELL=3; each row is one clock edge.
// Rows flagged "blank" are the first output cycle of a dwell and expect zeros when SCAN_MUX_BLANK_EN is set.
module tb_scan_mux_n;

    localparam int WIDTH    = 6;
    localparam int CHANNELS = 4;
    localparam int DWELL    = 3;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      reset;
    logic                      en;
    logic [CHANNELS-1:0]       ch_mask;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          f;
    logic [CHANNELS-1:0]       sel_onehot;
    logic                      valid;
    logic                      frame_done;

    typedef struct {
        logic       en;
        logic [3:0] mask;
        logic [1:0] sel;
        logic [5:0] f;
        logic [3:0] oh;
        logic       v;
        logic       fd;
        logic       blank;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    scan_mux_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ch_mask    (ch_mask),
        .data_in    (data_in),
        .sel        (sel),
        .f          (f),
        .sel_onehot (sel_onehot),
        .valid      (valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic [3:0] m, input logic [1:0] s, input logic [5:0] fv,
                       input logic [3:0] o, input logic v, input logic fd, input logic b);
        vec_t r;
        r.en = e; r.mask = m; r.sel = s; r.f = fv; r.oh = o; r.v = v; r.fd = fd; r.blank = b;
        vecs.push_back(r);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        ch_mask  = 4'b0000;
        data_in  = {6'd13, 6'd12, 6'd11, 6'd10};

        // full mask scan 0..3 and wrap
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd1, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd2, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd3, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd3, 6'd13, 4'b1000, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd3, 6'd13, 4'b1000, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd0, 6'd13, 4'b1000, 1'b1, 1'b1, 1'b0);
        // mask 0101: alternate 0 and 2
        add(1'b1, 4'h5, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'h5, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h5, 2'd2, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h5, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'h5, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h5, 2'd0, 6'd12, 4'b0100, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h5, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b1);
        // empty mask: outputs clear, sel holds
        add(1'b1, 4'h0, 2'd0, 6'd0,  4'b0000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 2'd0, 6'd0,  4'b0000, 1'b0, 1'b0, 1'b1);
        // restart, then freeze on channel 1 at cnt=1
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(1'b0, 4'hF, 2'd1, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd2, 6'd11, 4'b0010, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd3, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd3, 6'd13, 4'b1000, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd3, 6'd13, 4'b1000, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd0, 6'd13, 4'b1000, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b1);
        add(1'b1, 4'hF, 2'd0, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'hF, 2'd1, 6'd10, 4'b0001, 1'b1, 1'b0, 1'b0);
        // channel 1 disabled at cnt=0: jump to 2 at once
        add(1'b1, 4'hD, 2'd2, 6'd0,  4'b0000, 1'b0, 1'b0, 1'b1);
        add(1'b1, 4'hD, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b1);
        // single enabled channel: self-advance raises frame_done
        add(1'b1, 4'h4, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h4, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b1, 1'b0);
        add(1'b1, 4'h4, 2'd2, 6'd12, 4'b0100, 1'b1, 1'b0, 1'b1);

        #12;
        chk("rst_sel",   32'(sel),        32'd0);
        chk("rst_f",     32'(f),          32'd0);
        chk("rst_oh",    32'(sel_onehot), 32'd0);
        chk("rst_valid", 32'(valid),      32'd0);
        chk("rst_fd",    32'(frame_done), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        en      = vecs[0].en;
        ch_mask = vecs[0].mask;

        for (int i = 0; i < vecs.size(); i++) begin
            logic       bl;
            logic [5:0] ef;
            logic [3:0] eo;
            logic       ev;
            en      = vecs[i].en;
            ch_mask = vecs[i].mask;
            @(posedge clk);
            #1;
`ifdef SCAN_MUX_BLANK_EN
            bl = vecs[i].blank;
`else
            bl = 1'b0;
`endif
            ef = bl ? 6'd0 : vecs[i].f;
            eo = bl ? 4'd0 : vecs[i].oh;
            ev = bl ? 1'b0 : vecs[i].v;
            chk($sformatf("row%0d_sel", i),   32'(sel),        32'(vecs[i].sel));
            chk($sformatf("row%0d_f", i),     32'(f),          32'(ef));
            chk($sformatf("row%0d_oh", i),    32'(sel_onehot), 32'(eo));
            chk($sformatf("row%0d_valid", i), 32'(valid),      32'(ev));
            chk($sformatf("row%0d_fd", i),    32'(frame_done), 32'(vecs[i].fd));
        end

        // asynchronous reset mid-scan, checked before any clock edge
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_sel",   32'(sel),        32'd0);
        chk("arst_f",     32'(f),          32'd0);
        chk("arst_oh",    32'(sel_onehot), 32'd0);
        chk("arst_valid", 32'(valid),      32'd0);
        chk("arst_fd",    32'(frame_done), 32'd0);

        @(negedge clk);
        reset   = 1'b0;
        en      = 1'b1;
        ch_mask = 4'hF;
        @(posedge clk);
        #1;
        chk("post_sel", 32'(sel), 32'd0);
`ifdef SCAN_MUX_BLANK_EN
        chk("post_f",     32'(f),     32'd0);
        chk("post_valid", 32'(valid), 32'd0);
`else
        chk("post_f",     32'(f),     32'd10);
        chk("post_valid", 32'(valid), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
